// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of a single-port 256x16 synchronous RAM (round-robin on ties).
// Define PRIO_PORT_A_EN to give port A fixed priority on ties instead.
module mem_port_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int RAM_AW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        a_cmd,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_grant,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic [1:0]        b_cmd,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_grant,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [1:0] MREAD  = 2'd1;
   localparam logic [1:0] MWRITE = 2'd3;
   localparam logic       PORT_A = 1'b0;
   localparam logic       PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RDWAIT
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                wr_q, wr_d;
   logic [RAM_AW-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
   logic                a_rvalid_q, a_rvalid_d;
   logic                b_rvalid_q, b_rvalid_d;
`ifndef PRIO_PORT_A_EN
   logic                last_winner_q, last_winner_d;
`endif

   logic a_valid, b_valid, pick_b;

   // I/O-space requests (address MSB set) are invisible to this block.
   assign a_valid = ((a_cmd == MREAD) || (a_cmd == MWRITE)) && !a_addr[ADDR_W-1];
   assign b_valid = ((b_cmd == MREAD) || (b_cmd == MWRITE)) && !b_addr[ADDR_W-1];

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      a_rvalid_d = 1'b0;
      b_rvalid_d = 1'b0;
`ifndef PRIO_PORT_A_EN
      last_winner_d = last_winner_q;
`endif
      pick_b     = 1'b0;
      a_grant    = 1'b0;
      b_grant    = 1'b0;
      ram_write  = 1'b0;

      case (state_q)
         IDLE: begin
            if (a_valid || b_valid) begin
               if (a_valid && b_valid) begin
`ifdef PRIO_PORT_A_EN
                  pick_b = 1'b0;
`else
                  pick_b = (last_winner_q == PORT_A);
`endif
               end else begin
                  pick_b = b_valid;
               end
               owner_d = pick_b ? PORT_B : PORT_A;
               wr_d    = pick_b ? (b_cmd == MWRITE) : (a_cmd == MWRITE);
               addr_d  = pick_b ? b_addr[RAM_AW-1:0] : a_addr[RAM_AW-1:0];
               wdata_d = pick_b ? b_wdata : a_wdata;
`ifndef PRIO_PORT_A_EN
               last_winner_d = owner_d;
`endif
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            a_grant   = (owner_q == PORT_A);
            b_grant   = (owner_q == PORT_B);
            ram_write = wr_q;
            state_d   = wr_q ? IDLE : RDWAIT;
         end
         RDWAIT: begin
            // RAM output is valid now; rvalid is registered so it lands in the next IDLE.
            if (owner_q == PORT_B) begin
               b_rdata_d  = ram_dout;
               b_rvalid_d = 1'b1;
            end else begin
               a_rdata_d  = ram_dout;
               a_rvalid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= PORT_A;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
`ifndef PRIO_PORT_A_EN
         last_winner_q <= PORT_B;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
`ifndef PRIO_PORT_A_EN
         last_winner_q <= last_winner_d;
`endif
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
   assign ram_addr = addr_q;
   assign ram_din  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: read data expected at drive time, checked on rvalid.
// Grant order, latency, I/O filtering and mid-read reset are checked per scenario task.
module tb_mem_port_arbiter;

   localparam logic [1:0] MREAD  = 2'd1;
   localparam logic [1:0] MNONE  = 2'd2;
   localparam logic [1:0] MWRITE = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  a_cmd, b_cmd;
   logic [8:0]  a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
   logic        a_grant, b_grant, a_rvalid, b_rvalid, ram_write;
   logic [7:0]  ram_addr;

   logic [15:0] ram_mem [256];
   logic [15:0] sb_mem  [256];

   logic [15:0] a_exp[$];
   logic [15:0] b_exp[$];
   byte         grant_log[$];
   logic [15:0] mon_exp;

   int passes = 0;
   int checks = 0;
   int cyc = 0;
   int n_ram_write = 0, n_b_grant = 0, n_b_rvalid = 0, n_a_rvalid = 0;
   int a_rvalid_cyc = -1;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_grant(a_grant), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_grant(b_grant), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM: registered read, old data on read-during-write.
   always @(posedge clk) begin
      if (ram_write) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (a_grant === 1'b1) grant_log.push_back("A");
         if (b_grant === 1'b1) begin grant_log.push_back("B"); n_b_grant++; end
         if (ram_write === 1'b1) n_ram_write++;
         if (a_rvalid === 1'b1) begin
            n_a_rvalid++;
            a_rvalid_cyc = cyc;
            checks++;
            if (a_exp.size() == 0) $display("FAIL a_rvalid_unexpected: a_rdata=%h, no read outstanding", a_rdata);
            else begin
               mon_exp = a_exp.pop_front();
               if (a_rdata !== mon_exp) $display("FAIL a_rdata: got %h expected %h", a_rdata, mon_exp);
               else passes++;
            end
         end
         if (b_rvalid === 1'b1) begin
            n_b_rvalid++;
            checks++;
            if (b_exp.size() == 0) $display("FAIL b_rvalid_unexpected: b_rdata=%h, no read outstanding", b_rdata);
            else begin
               mon_exp = b_exp.pop_front();
               if (b_rdata !== mon_exp) $display("FAIL b_rdata: got %h expected %h", b_rdata, mon_exp);
               else passes++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
      $fatal(1);
   end

   // Present one request, hold it until granted, then drop to MNONE the cycle after grant.
   task automatic req(input bit port, input logic [1:0] cmd, input logic [8:0] addr,
                      input logic [15:0] wdata, output int req_cyc, output int gnt_cyc);
      bit seen = 1'b0;
      if (port == 1'b0) begin a_cmd = cmd; a_addr = addr; a_wdata = wdata; end
      else begin b_cmd = cmd; b_addr = addr; b_wdata = wdata; end
      if (cmd == MWRITE) sb_mem[addr[7:0]] = wdata;
      else if (port == 1'b0) a_exp.push_back(sb_mem[addr[7:0]]);
      else b_exp.push_back(sb_mem[addr[7:0]]);
      req_cyc = cyc;
      gnt_cyc = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (((port == 1'b0) ? a_grant : b_grant) === 1'b1) begin
            seen = 1'b1;
            gnt_cyc = cyc;
         end
      end
      checks++;
      if (!seen) $display("FAIL grant_timeout port %s: no grant in 40 cycles", port ? "B" : "A");
      else passes++;
      @(posedge clk); #1;
      if (port == 1'b0) a_cmd = MNONE; else b_cmd = MNONE;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 && (a_exp.size() != 0 || b_exp.size() != 0); i++) @(negedge clk);
      @(posedge clk); #1;
      checks++;
      if (a_exp.size() != 0 || b_exp.size() != 0)
         $display("FAIL %s_drain: outstanding reads A=%0d B=%0d, expected 0", name, a_exp.size(), b_exp.size());
      else passes++;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      a_cmd = MNONE; a_addr = '0; a_wdata = '0;
      b_cmd = MNONE; b_addr = '0; b_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      grant_log.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_cmd = MNONE; b_cmd = MNONE;
      a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({a_grant, b_grant, a_rvalid, b_rvalid, ram_write} !== 5'b0)
         $display("FAIL reset_ctrl: got %b expected 00000", {a_grant, b_grant, a_rvalid, b_rvalid, ram_write});
      else passes++;
      checks++;
      if ({a_rdata, b_rdata, ram_addr, ram_din} !== '0)
         $display("FAIL reset_data: got %h/%h/%h/%h expected 0", a_rdata, b_rdata, ram_addr, ram_din);
      else passes++;
      reset = 1'b0;
      grant_log.delete();
   endtask

   task automatic test_write_read();
      int r, g, bg0;
      bg0 = n_b_grant;
      req(1'b0, MWRITE, 9'h005, 16'hBEEF, r, g);
      checks++;
      if (g != r + 1) $display("FAIL wr_grant_latency: got %0d expected %0d", g - r, 1);
      else passes++;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ram_mem[5] !== 16'hBEEF) $display("FAIL ram5_written: got %h expected BEEF", ram_mem[5]);
      else passes++;
      req(1'b0, MREAD, 9'h005, 16'h0000, r, g);
      checks++;
      if (g != r + 1) $display("FAIL rd_grant_latency: got %0d expected %0d", g - r, 1);
      else passes++;
      wait_drain("write_read");
      checks++;
      if (a_rvalid_cyc != r + 3) $display("FAIL rd_rvalid_latency: got %0d expected %0d", a_rvalid_cyc - r, 3);
      else passes++;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (a_rdata !== 16'hBEEF) $display("FAIL a_rdata_hold: got %h expected BEEF", a_rdata);
      else passes++;
      checks++;
      if (n_b_grant != bg0) $display("FAIL b_grant_idle: got %0d grants expected 0", n_b_grant - bg0);
      else passes++;
   endtask

   task automatic test_tie();
      int ra, ga, rb, gb;
      apply_reset();
      fork
         req(1'b0, MWRITE, 9'h001, 16'h0011, ra, ga);
         req(1'b1, MWRITE, 9'h002, 16'h0022, rb, gb);
      join
      checks++;
      if (grant_log.size() != 2) $display("FAIL tie_grant_count: got %0d expected 2", grant_log.size());
      else if ({grant_log[0], grant_log[1]} !== {8'h41, 8'h42})
         $display("FAIL tie_order: got %s%s expected AB", grant_log[0], grant_log[1]);
      else passes++;
   endtask

   task automatic test_round_robin();
      string exp_order;
`ifdef PRIO_PORT_A_EN
      exp_order = "AAAABBBB";
`else
      exp_order = "ABABABAB";
`endif
      apply_reset();
      fork
         begin
            int r, g;
            for (int i = 0; i < 4; i++) req(1'b0, MREAD, 9'h001, 16'h0000, r, g);
         end
         begin
            int r, g;
            for (int i = 0; i < 4; i++) req(1'b1, MREAD, 9'h002, 16'h0000, r, g);
         end
      join
      wait_drain("round_robin");
      checks++;
      if (grant_log.size() != 8) $display("FAIL rr_grant_count: got %0d expected 8", grant_log.size());
      else passes++;
      for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
         checks++;
         if (grant_log[i] !== exp_order[i])
            $display("FAIL rr_order[%0d]: got %s expected %s", i, grant_log[i], exp_order[i]);
         else passes++;
      end
   endtask

   task automatic test_io_block();
      int r, g, w0, bg0, bv0;
      apply_reset();
      req(1'b0, MWRITE, 9'h003, 16'h0333, r, g);
      @(posedge clk); #1;
      w0 = n_ram_write; bg0 = n_b_grant; bv0 = n_b_rvalid;
      grant_log.delete();
      b_cmd = MWRITE; b_addr = 9'h100; b_wdata = 16'hDEAD;
      req(1'b0, MREAD, 9'h003, 16'h0000, r, g);
      checks++;
      if (g != r + 1) $display("FAIL io_a_latency: got %0d expected 1", g - r);
      else passes++;
      wait_drain("io_block");
      repeat (4) @(posedge clk);
      #1;
      b_cmd = MNONE;
      checks++;
      if (n_ram_write != w0) $display("FAIL io_ram_write: got %0d writes expected 0", n_ram_write - w0);
      else passes++;
      checks++;
      if (n_b_grant != bg0 || n_b_rvalid != bv0)
         $display("FAIL io_b_activity: got grants %0d rvalids %0d expected 0 0", n_b_grant - bg0, n_b_rvalid - bv0);
      else passes++;
      checks++;
      if (grant_log.size() != 1) $display("FAIL io_grant_count: got %0d expected 1", grant_log.size());
      else passes++;
   endtask

   task automatic test_reset_mid_read();
      int r, g, av0;
      req(1'b0, MREAD, 9'h005, 16'h0000, r, g);
      reset = 1'b1;
      #1;
      checks++;
      if ({a_grant, b_grant, a_rvalid, b_rvalid, ram_write} !== 5'b0)
         $display("FAIL midrst_ctrl: got %b expected 00000", {a_grant, b_grant, a_rvalid, b_rvalid, ram_write});
      else passes++;
      checks++;
      if ({a_rdata, b_rdata, ram_addr, ram_din} !== '0)
         $display("FAIL midrst_data: got %h/%h/%h/%h expected 0", a_rdata, b_rdata, ram_addr, ram_din);
      else passes++;
      a_exp.delete();
      av0 = n_a_rvalid;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (n_a_rvalid != av0) $display("FAIL midrst_rvalid: got %0d rvalids expected 0", n_a_rvalid - av0);
      else passes++;
      req(1'b0, MREAD, 9'h005, 16'h0000, r, g);
      checks++;
      if (g != r + 1) $display("FAIL midrst_recover_latency: got %0d expected 1", g - r);
      else passes++;
      wait_drain("reset_mid_read");
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = '0;
         sb_mem[i]  = '0;
      end
      test_reset();
      test_write_read();
      test_tie();
      test_round_robin();
      test_io_block();
      test_reset_mid_read();
      checks++;
      if (a_exp.size() != 0 || b_exp.size() != 0)
         $display("FAIL final_queues: A=%0d B=%0d expected 0 0", a_exp.size(), b_exp.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
